// File: rtl/output_arbiter_4.sv
// output_arbiter_4: per-output round-robin arbiter for a 4-input NoC switch stage.
// Holds a registered one-hot grant for a whole wormhole packet (or one flit when LOCK_EN = 0).
`default_nettype none

module output_arbiter_4 #(
   parameter bit LOCK_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [3:0] req_i,
   input  logic [3:0] tail_i,
   input  logic       out_ready_i,
   output logic [3:0] grant_o,
   output logic [3:0] ack_o,
   output logic       valid_o,
   output logic       busy_o
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t     state, state_next;
   logic [3:0] grant, grant_next;
   logic [1:0] ptr, ptr_next;
   logic [3:0] winner;
   logic [1:0] gidx;
   logic       transfer;
   logic       release_grant;

   // Round-robin scan starting at ptr; first requester wins.
   always_comb begin
      logic       found;
      logic [1:0] idx;
      winner = 4'b0000;
      found  = 1'b0;
      idx    = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req_i[idx]) begin
            winner = 4'b0001 << idx;
            found  = 1'b1;
         end
      end
   end

   assign gidx          = {grant[3] | grant[2], grant[3] | grant[1]};
   assign transfer      = (|(grant & req_i)) & out_ready_i;
   assign release_grant = transfer & (tail_i[gidx] | !LOCK_EN);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         grant <= 4'b0000;
         ptr   <= 2'd0;
      end else begin
         state <= state_next;
         grant <= grant_next;
         ptr   <= ptr_next;
      end
   end

   always_comb begin
      state_next = state;
      grant_next = grant;
      ptr_next   = ptr;
      case (state)
         IDLE: begin
            grant_next = 4'b0000;
            if (|req_i) begin
               grant_next = winner;
               state_next = LOCKED;
            end
         end
         LOCKED: begin
            if (release_grant) begin
               grant_next = 4'b0000;
               state_next = IDLE;
               ptr_next   = gidx + 2'd1;
            end
         end
         default: begin
            grant_next = 4'b0000;
            state_next = IDLE;
         end
      endcase
   end

   assign grant_o = grant;
   assign ack_o   = grant & req_i & {4{out_ready_i}};
   assign valid_o = |(grant & req_i);
   assign busy_o  = (state == LOCKED);

   a_onehot0 : assert property (@(posedge clk) disable iff (!rstn) $onehot0(grant_o));
   a_ack_sub : assert property (@(posedge clk) disable iff (!rstn) (ack_o & ~grant_o) == 4'b0000);
   a_lock    : assert property (@(posedge clk) disable iff (!rstn) ((grant_o != 4'b0000) == (state == LOCKED)));

endmodule

`default_nettype wire

// File: tb/tb_output_arbiter_4.sv
// Directed self-checking bench for output_arbiter_4 (wormhole and per-flit variants).
`default_nettype none

module tb_output_arbiter_4;

   logic       clk = 1'b0;
   logic       rstn;
   logic [3:0] req_i;
   logic [3:0] tail_i;
   logic       out_ready_i;
   logic [3:0] grant_o, ack_o;
   logic       valid_o, busy_o;
   logic [3:0] grant_nl, ack_nl;
   logic       valid_nl, busy_nl;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   output_arbiter_4 #(.LOCK_EN(1'b1)) dut (
      .clk(clk), .rstn(rstn), .req_i(req_i), .tail_i(tail_i), .out_ready_i(out_ready_i),
      .grant_o(grant_o), .ack_o(ack_o), .valid_o(valid_o), .busy_o(busy_o)
   );

   output_arbiter_4 #(.LOCK_EN(1'b0)) dut_nl (
      .clk(clk), .rstn(rstn), .req_i(req_i), .tail_i(tail_i), .out_ready_i(out_ready_i),
      .grant_o(grant_nl), .ack_o(ack_nl), .valid_o(valid_nl), .busy_o(busy_nl)
   );

   // Advance to just after the next rising edge, then let inputs settle before sampling.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn        = 1'b0;
      req_i       = 4'b0000;
      tail_i      = 4'b0000;
      out_ready_i = 1'b1;
      cyc();
      cyc();
      rstn = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if ({grant_o, ack_o, valid_o, busy_o} !== 10'b0) $display("FAIL reset_outputs got=%b want=%b", {grant_o, ack_o, valid_o, busy_o}, 10'b0); else passed++;
      cyc();
      total++; if (grant_o !== 4'b0000) $display("FAIL reset_idle_hold got=%b want=0000", grant_o); else passed++;
   endtask

   task automatic test_basic_packet();
      do_reset();
      req_i = 4'b0110;
      #1;
      total++; if (grant_o !== 4'b0000) $display("FAIL basic_arb_latency got=%b want=0000", grant_o); else passed++;
      for (int f = 0; f < 3; f++) begin
         cyc();
         tail_i = (f == 2) ? 4'b0010 : 4'b0000;
         #1;
         total++; if (grant_o !== 4'b0010) $display("FAIL basic_grant f%0d got=%b want=0010", f, grant_o); else passed++;
         total++; if (ack_o !== 4'b0010) $display("FAIL basic_ack f%0d got=%b want=0010", f, ack_o); else passed++;
      end
      cyc();
      tail_i = 4'b0000;
      #1;
      total++; if ({grant_o, busy_o} !== 5'b00000) $display("FAIL basic_bubble got=%b want=00000", {grant_o, busy_o}); else passed++;
      cyc();
      total++; if (grant_o !== 4'b0100) $display("FAIL basic_next_grant got=%b want=0100", grant_o); else passed++;
   endtask

   task automatic test_round_robin();
      logic [3:0] want;
      do_reset();
      req_i = 4'b1111;
      cyc();
      for (int p = 0; p < 5; p++) begin
         want = 4'b0001 << (p % 4);
         total++; if (grant_o !== want || ack_o !== want) $display("FAIL rr_flit1 p%0d got=%b/%b want=%b", p, grant_o, ack_o, want); else passed++;
         cyc();
         tail_i = want;
         #1;
         total++; if (ack_o !== want) $display("FAIL rr_flit2 p%0d got=%b want=%b", p, ack_o, want); else passed++;
         cyc();
         tail_i = 4'b0000;
         #1;
         total++; if (grant_o !== 4'b0000) $display("FAIL rr_bubble p%0d got=%b want=0000", p, grant_o); else passed++;
         cyc();
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] ready_seq;
      do_reset();
      req_i = 4'b1000;
      ready_seq = 4'b1001;
      for (int c = 0; c < 4; c++) begin
         cyc();
         out_ready_i = ready_seq[c];
         tail_i      = (c == 0) ? 4'b0000 : 4'b1000;
         #1;
         total++; if (grant_o !== 4'b1000) $display("FAIL bp_grant c%0d got=%b want=1000", c, grant_o); else passed++;
         total++; if (ack_o !== (ready_seq[c] ? 4'b1000 : 4'b0000) || valid_o !== 1'b1)
            $display("FAIL bp_ack c%0d got=%b/%b want=%b/1", c, ack_o, valid_o, ready_seq[c] ? 4'b1000 : 4'b0000); else passed++;
      end
      cyc();
      out_ready_i = 1'b1;
      tail_i      = 4'b0000;
      req_i       = 4'b0000;
      #1;
      total++; if (grant_o !== 4'b0000) $display("FAIL bp_release got=%b want=0000", grant_o); else passed++;
   endtask

   task automatic test_upstream_gap();
      do_reset();
      req_i = 4'b0101;
      cyc();
      total++; if (ack_o !== 4'b0001) $display("FAIL gap_first_ack got=%b want=0001", ack_o); else passed++;
      for (int c = 0; c < 2; c++) begin
         cyc();
         req_i = 4'b0100;
         #1;
         total++; if ({grant_o, valid_o, ack_o} !== {4'b0001, 1'b0, 4'b0000})
            $display("FAIL gap_hold c%0d got=%b want=000100000", c, {grant_o, valid_o, ack_o}); else passed++;
      end
      cyc();
      req_i  = 4'b0101;
      tail_i = 4'b0001;
      #1;
      total++; if (ack_o !== 4'b0001) $display("FAIL gap_tail_ack got=%b want=0001", ack_o); else passed++;
      cyc();
      tail_i = 4'b0000;
      #1;
      total++; if (grant_o !== 4'b0000) $display("FAIL gap_bubble got=%b want=0000", grant_o); else passed++;
      cyc();
      total++; if (grant_o !== 4'b0100) $display("FAIL gap_next got=%b want=0100", grant_o); else passed++;
   endtask

   task automatic test_no_lock();
      logic [3:0] seq [5];
      seq = '{4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
      do_reset();
      req_i = 4'b1001;
      for (int c = 0; c < 5; c++) begin
         cyc();
         total++; if (grant_nl !== seq[c] || ack_nl !== seq[c]) $display("FAIL nolock c%0d got=%b/%b want=%b", c, grant_nl, ack_nl, seq[c]); else passed++;
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req_i = 4'b0100;
      cyc();
      cyc();
      total++; if (grant_o !== 4'b0100) $display("FAIL ar_pre got=%b want=0100", grant_o); else passed++;
      #2;
      rstn = 1'b0;
      #1;
      total++; if ({grant_o, busy_o} !== 5'b00000) $display("FAIL ar_async got=%b want=00000", {grant_o, busy_o}); else passed++;
      cyc();
      rstn  = 1'b1;
      req_i = 4'b1111;
      #1;
      total++; if (grant_o !== 4'b0000) $display("FAIL ar_idle got=%b want=0000", grant_o); else passed++;
      cyc();
      total++; if (grant_o !== 4'b0001) $display("FAIL ar_ptr got=%b want=0001", grant_o); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic_packet();
      test_round_robin();
      test_backpressure();
      test_upstream_gap();
      test_no_lock();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule

`default_nettype wire
